lsu_noc_bridge: RTL



---
 rtl/lsu_noc_pkg.sv | 28 ++
 rtl/lsu_noc_beat_buf.sv | 46 ++++
 rtl/lsu_noc_bridge.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_noc_pkg.sv
// Shared constants and FSM state type for the LSU-to-NoC bridge.
package lsu_noc_pkg;

   localparam int MSG_LENGTH_HI = 29;
   localparam int MSG_LENGTH_LO = 22;
   localparam int MSG_TYPE_HI   = 21;
   localparam int MSG_TYPE_LO   = 14;
   localparam int MSHRID_HI     = 13;
   localparam int MSHRID_LO     = 6;
   localparam int ADDR_HI       = 39;

   localparam logic [7:0] MSG_TYPE_LOAD_MEM  = 8'd19;
   localparam logic [7:0] MSG_TYPE_STORE_MEM = 8'd20;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_COLLECT,
      ST_HDR1,
      ST_HDR2,
      ST_HDR3,
      ST_WR_DATA,
      ST_WR_ACK_WAIT,
      ST_RD_RSP_HDR,
      ST_RD_RSP_DATA,
      ST_RSP_OUT
   } bridge_state_e;

endpackage

// File: rtl/lsu_noc_beat_buf.sv
// Beat storage shared by the write-collect and read-response paths.
// Beat k lives in lane k%R of flit k/R; out-of-range indices read as zero.
module lsu_noc_beat_buf #(
   parameter int LSU_DATA_WIDTH = 32,
   parameter int NOC_DATA_WIDTH = 64,
   parameter int MAX_BEATS      = 64,
   parameter int IDX_W          = 7,
   parameter int FIDX_W         = 9
) (
   input  logic                      clk,
   input  logic                      beat_we_i,
   input  logic [IDX_W-1:0]          beat_widx_i,
   input  logic [LSU_DATA_WIDTH-1:0] beat_wdata_i,
   input  logic                      flit_we_i,
   input  logic [FIDX_W-1:0]         flit_idx_i,
   input  logic [NOC_DATA_WIDTH-1:0] flit_wdata_i,
   output logic [NOC_DATA_WIDTH-1:0] flit_rdata_o,
   input  logic [IDX_W-1:0]          beat_ridx_i,
   output logic [LSU_DATA_WIDTH-1:0] beat_rdata_o
);

   localparam int R = NOC_DATA_WIDTH / LSU_DATA_WIDTH;

   logic [MAX_BEATS*LSU_DATA_WIDTH-1:0] mem_q;

   always_ff @(posedge clk) begin
      for (int i = 0; i < MAX_BEATS; i++) begin
         if (beat_we_i && int'(beat_widx_i) == i)
            mem_q[i*LSU_DATA_WIDTH +: LSU_DATA_WIDTH] <= beat_wdata_i;
         else if (flit_we_i && int'(flit_idx_i) == i / R)
            mem_q[i*LSU_DATA_WIDTH +: LSU_DATA_WIDTH] <= flit_wdata_i[(i % R)*LSU_DATA_WIDTH +: LSU_DATA_WIDTH];
      end
   end

   always_comb begin
      flit_rdata_o = '0;
      beat_rdata_o = '0;
      for (int i = 0; i < MAX_BEATS; i++) begin
         if (int'(flit_idx_i) == i / R)
            flit_rdata_o[(i % R)*LSU_DATA_WIDTH +: LSU_DATA_WIDTH] = mem_q[i*LSU_DATA_WIDTH +: LSU_DATA_WIDTH];
         if (int'(beat_ridx_i) == i)
            beat_rdata_o = mem_q[i*LSU_DATA_WIDTH +: LSU_DATA_WIDTH];
      end
   end

endmodule

// File: rtl/lsu_noc_bridge.sv
// LSU-to-NoC bridge: turns LSU write bursts / read requests into NoC request
// packets (3 header flits + data) and returns NoC responses as LSU beats.
module lsu_noc_bridge
   import lsu_noc_pkg::*;
#(
   parameter int LSU_DATA_WIDTH = 32,
   parameter int NOC_DATA_WIDTH = 64,
   parameter int MAX_BEATS      = 64,
   parameter int TAG_WIDTH      = 7,
   parameter int ADDR_WIDTH     = 32
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             req_val,
   output logic                             req_rdy,
   input  logic                             req_we,
   input  logic [ADDR_WIDTH-1:0]            req_addr,
   input  logic [LSU_DATA_WIDTH-1:0]        req_wdata,
   input  logic                             req_last,
   input  logic [$clog2(MAX_BEATS+1)-1:0]   req_beats,
   input  logic [TAG_WIDTH-1:0]             req_tag,
   output logic                             rsp_val,
   input  logic                             rsp_rdy,
   output logic [LSU_DATA_WIDTH-1:0]        rsp_data,
   output logic [TAG_WIDTH-1:0]             rsp_tag,
   output logic                             rsp_last,
   output logic                             rsp_err,
   output logic                             noc2_filter_val,
   input  logic                             filter_noc2_rdy,
   output logic [NOC_DATA_WIDTH-1:0]        noc2_filter_data,
   input  logic                             filter_noc3_val,
   output logic                             noc3_filter_rdy,
   input  logic [NOC_DATA_WIDTH-1:0]        filter_noc3_data,
   output bridge_state_e                    dbg_state
);

   localparam int R      = NOC_DATA_WIDTH / LSU_DATA_WIDTH;
   localparam int NFLITS = (MAX_BEATS + R - 1) / R;
   localparam int BW     = $clog2(MAX_BEATS + 1);
   localparam int FW     = 9;

   bridge_state_e         state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [TAG_WIDTH-1:0]  tag_q, tag_d, rsp_tag_q, rsp_tag_d;
   logic [BW-1:0]         beats_q, beats_d, beat_cnt_q, beat_cnt_d;
   logic [FW-1:0]         flit_cnt_q, flit_cnt_d;
   logic [7:0]            len_q, len_d;
   logic                  we_q, we_d, err_q, err_d;

   logic                      bw_en, fw_en;
   logic [BW-1:0]             bw_idx;
   logic [NOC_DATA_WIDTH-1:0] buf_flit, hdr1, hdr2, data_flit;
   logic [LSU_DATA_WIDTH-1:0] buf_beat;
   logic [7:0]                wr_flits;
   logic [BW-1:0]             rsp_beats;
   logic                      covered;

   lsu_noc_beat_buf #(
      .LSU_DATA_WIDTH(LSU_DATA_WIDTH),
      .NOC_DATA_WIDTH(NOC_DATA_WIDTH),
      .MAX_BEATS     (MAX_BEATS),
      .IDX_W         (BW),
      .FIDX_W        (FW)
   ) u_buf (
      .clk         (clk),
      .beat_we_i   (bw_en),
      .beat_widx_i (bw_idx),
      .beat_wdata_i(req_wdata),
      .flit_we_i   (fw_en),
      .flit_idx_i  (flit_cnt_q),
      .flit_wdata_i(filter_noc3_data),
      .flit_rdata_o(buf_flit),
      .beat_ridx_i (beat_cnt_q),
      .beat_rdata_o(buf_beat)
   );

   always_comb begin
      wr_flits  = 8'((int'(beats_q) + R - 1) / R);
      rsp_beats = we_q ? BW'(1) : beats_q;
      // A response beat is real data only if a received flit carried it.
      covered   = (int'(beat_cnt_q) < MAX_BEATS) && (int'(beat_cnt_q) < int'(flit_cnt_q) * R);
      hdr1 = '0;
      hdr1[MSG_LENGTH_HI:MSG_LENGTH_LO] = we_q ? 8'd2 + wr_flits : 8'd2;
      hdr1[MSG_TYPE_HI:MSG_TYPE_LO]     = we_q ? MSG_TYPE_STORE_MEM : MSG_TYPE_LOAD_MEM;
      hdr1[MSHRID_LO +: TAG_WIDTH]      = tag_q;
      hdr2 = '0;
      hdr2[ADDR_HI:0] = 40'(addr_q);
      data_flit = '0;
      for (int l = 0; l < R; l++)
         if (int'(flit_cnt_q) * R + l < int'(beats_q))
            data_flit[l*LSU_DATA_WIDTH +: LSU_DATA_WIDTH] = buf_flit[l*LSU_DATA_WIDTH +: LSU_DATA_WIDTH];
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      tag_d      = tag_q;
      we_d       = we_q;
      beats_d    = beats_q;
      err_d      = err_q;
      flit_cnt_d = flit_cnt_q;
      len_d      = len_q;
      rsp_tag_d  = rsp_tag_q;
      beat_cnt_d = beat_cnt_q;
      bw_en      = 1'b0;
      bw_idx     = beats_q;
      fw_en      = 1'b0;
      req_rdy          = 1'b0;
      noc2_filter_val  = 1'b0;
      noc2_filter_data = '0;
      noc3_filter_rdy  = 1'b0;
      rsp_val  = 1'b0;
      rsp_data = '0;
      rsp_tag  = '0;
      rsp_last = 1'b0;
      rsp_err  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            req_rdy = rst_n;
            if (req_val && rst_n) begin
               addr_d = req_addr;
               tag_d  = req_tag;
               we_d   = req_we;
               err_d  = 1'b0;
               if (req_we) begin
                  bw_en   = 1'b1;
                  bw_idx  = '0;
                  beats_d = BW'(1);
                  state_d = req_last ? ST_HDR1 : ST_WR_COLLECT;
               end else begin
                  beats_d = (req_beats == '0) ? BW'(1) : req_beats;
                  state_d = ST_HDR1;
               end
            end
         end
         ST_WR_COLLECT: begin
            req_rdy = rst_n;
            if (req_val) begin
               if (int'(beats_q) < MAX_BEATS) begin
                  bw_en   = 1'b1;
                  beats_d = beats_q + BW'(1);
               end else begin
                  err_d = 1'b1;
               end
               if (req_last) state_d = ST_HDR1;
            end
         end
         ST_HDR1: begin
            noc2_filter_val  = 1'b1;
            noc2_filter_data = hdr1;
            if (filter_noc2_rdy) state_d = ST_HDR2;
         end
         ST_HDR2: begin
            noc2_filter_val  = 1'b1;
            noc2_filter_data = hdr2;
            if (filter_noc2_rdy) state_d = ST_HDR3;
         end
         ST_HDR3: begin
            noc2_filter_val = 1'b1;
            if (filter_noc2_rdy) begin
               flit_cnt_d = '0;
               state_d    = we_q ? ST_WR_DATA : ST_RD_RSP_HDR;
            end
         end
         ST_WR_DATA: begin
            noc2_filter_val  = 1'b1;
            noc2_filter_data = data_flit;
            if (filter_noc2_rdy) begin
               flit_cnt_d = flit_cnt_q + FW'(1);
               if (flit_cnt_q + FW'(1) == {1'b0, wr_flits}) state_d = ST_WR_ACK_WAIT;
            end
         end
         ST_WR_ACK_WAIT: begin
            noc3_filter_rdy = 1'b1;
            if (filter_noc3_val) begin
               rsp_tag_d  = filter_noc3_data[MSHRID_LO +: TAG_WIDTH];
               beat_cnt_d = '0;
               state_d    = ST_RSP_OUT;
            end
         end
         ST_RD_RSP_HDR: begin
            noc3_filter_rdy = 1'b1;
            if (filter_noc3_val) begin
               rsp_tag_d  = filter_noc3_data[MSHRID_LO +: TAG_WIDTH];
               len_d      = filter_noc3_data[MSG_LENGTH_HI:MSG_LENGTH_LO];
               flit_cnt_d = '0;
               beat_cnt_d = '0;
               state_d    = (filter_noc3_data[MSG_LENGTH_HI:MSG_LENGTH_LO] == 8'd0) ? ST_RSP_OUT : ST_RD_RSP_DATA;
            end
         end
         ST_RD_RSP_DATA: begin
            noc3_filter_rdy = 1'b1;
            if (filter_noc3_val) begin
               if (int'(flit_cnt_q) < NFLITS) fw_en = 1'b1;
               else                           err_d = 1'b1;
               flit_cnt_d = flit_cnt_q + FW'(1);
               if (flit_cnt_q + FW'(1) == {1'b0, len_q}) state_d = ST_RSP_OUT;
            end
         end
         ST_RSP_OUT: begin
            rsp_val  = 1'b1;
            rsp_data = (!we_q && covered) ? buf_beat : '0;
            rsp_tag  = rsp_tag_q;
            rsp_last = (beat_cnt_q == rsp_beats - BW'(1));
            rsp_err  = err_q || (rsp_tag_q != tag_q) || (!we_q && !covered);
            if (rsp_rdy) begin
               beat_cnt_d = beat_cnt_q + BW'(1);
               if (rsp_last) begin
                  err_d   = 1'b0;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         tag_q      <= '0;
         we_q       <= 1'b0;
         beats_q    <= '0;
         err_q      <= 1'b0;
         flit_cnt_q <= '0;
         len_q      <= '0;
         rsp_tag_q  <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         tag_q      <= tag_d;
         we_q       <= we_d;
         beats_q    <= beats_d;
         err_q      <= err_d;
         flit_cnt_q <= flit_cnt_d;
         len_q      <= len_d;
         rsp_tag_q  <= rsp_tag_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign dbg_state = state_q;

endmodule
